// File: rtl/parking_occupancy_counter_if.sv
// Gate-side signal bundle for the parking occupancy counter: raw photo-sensor
// beams towards the counter, occupancy status and passage strobes back out.
interface parking_occupancy_counter_if #(
  parameter int CW = 6
);
  logic          sensor_a;
  logic          sensor_b;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          enter_pulse;
  logic          exit_pulse;

  // Sensor/gate side: drives beams, observes occupancy.
  modport master (
    output sensor_a, sensor_b,
    input  count, full, empty, enter_pulse, exit_pulse
  );

  // Counter side: receives beams, reports occupancy.
  modport slave (
    input  sensor_a, sensor_b,
    output count, full, empty, enter_pulse, exit_pulse
  );
endinterface

// File: rtl/parking_occupancy_counter.sv
// Parking lot occupancy counter. Two beams (A outer, B inner) are synchronised,
// a direction FSM recognises full enter/exit passages, and a saturating count
// in 0..MAX_COUNT is maintained with registered one-cycle passage strobes.
module parking_occupancy_counter #(
  parameter int MAX_COUNT = 25,
  parameter int CW        = 6
) (
  input  logic                          clk,
  input  logic                          reset_n,
  parking_occupancy_counter_if.slave    bus
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);

  typedef enum logic [2:0] {
    IDLE,
    EN1,
    EN2,
    EN3,
    EX1,
    EX2,
    EX3,
    ABORT
  } state_t;

  logic          a_meta, b_meta;
  logic          a_s, b_s;
  logic [1:0]    ab;
  state_t        state_q, state_d;
  logic          enter_evt, exit_evt;
  logic [CW-1:0] count_q;
  logic          enter_q, exit_q;

  // Two-flop synchronisers for the asynchronous beam inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_meta <= 1'b0;
      b_meta <= 1'b0;
      a_s    <= 1'b0;
      b_s    <= 1'b0;
    end else begin
      a_meta <= bus.sensor_a;
      b_meta <= bus.sensor_b;
      a_s    <= a_meta;
      b_s    <= b_meta;
    end
  end

  assign ab = {a_s, b_s};

  // Direction FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; a passage is recognised on the final step back to 00.
  always_comb begin
    state_d   = state_q;
    enter_evt = 1'b0;
    exit_evt  = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (ab)
          2'b10: state_d = EN1;
          2'b01: state_d = EX1;
          2'b11: state_d = ABORT;
          default: state_d = IDLE;
        endcase
      end
      EN1: begin
        unique case (ab)
          2'b11: state_d = EN2;
          2'b00: state_d = IDLE;
          2'b01: state_d = ABORT;
          default: state_d = EN1;
        endcase
      end
      EN2: begin
        unique case (ab)
          2'b01: state_d = EN3;
          2'b10: state_d = EN1;
          2'b00: state_d = ABORT;
          default: state_d = EN2;
        endcase
      end
      EN3: begin
        unique case (ab)
          2'b00: begin
            state_d   = IDLE;
            enter_evt = 1'b1;
          end
          2'b11: state_d = EN2;
          2'b10: state_d = ABORT;
          default: state_d = EN3;
        endcase
      end
      EX1: begin
        unique case (ab)
          2'b11: state_d = EX2;
          2'b00: state_d = IDLE;
          2'b10: state_d = ABORT;
          default: state_d = EX1;
        endcase
      end
      EX2: begin
        unique case (ab)
          2'b10: state_d = EX3;
          2'b01: state_d = EX1;
          2'b00: state_d = ABORT;
          default: state_d = EX2;
        endcase
      end
      EX3: begin
        unique case (ab)
          2'b00: begin
            state_d  = IDLE;
            exit_evt = 1'b1;
          end
          2'b11: state_d = EX2;
          2'b01: state_d = ABORT;
          default: state_d = EX3;
        endcase
      end
      ABORT: begin
        if (ab == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating occupancy count and registered passage strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      enter_q <= enter_evt;
      exit_q  <= exit_evt;
      if (enter_evt && (count_q < MAX_C)) begin
        count_q <= count_q + 1'b1;
      end else if (exit_evt && (count_q != '0)) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign bus.count       = count_q;
  assign bus.full        = (count_q == MAX_C);
  assign bus.empty       = (count_q == '0);
  assign bus.enter_pulse = enter_q;
  assign bus.exit_pulse  = exit_q;

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Self-checking bench for parking_occupancy_counter. Passage tasks push the
// expected strobe/count into a scoreboard queue; every sampled strobe pops
// and compares against it.
module tb_parking_occupancy_counter;

  localparam int MAXC = 25;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  parking_occupancy_counter_if #(.CW(6)) pif();

  parking_occupancy_counter #(.MAX_COUNT(MAXC), .CW(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (pif)
  );

  int errors = 0;
  int checks = 0;
  int model_count = 0;
  logic [6:0] exp_q[$];   // {is_enter, count after passage}

  // One clock, sampled 1 time unit after the rising edge; any strobe is
  // matched against the scoreboard.
  task automatic tick();
    logic [6:0] e;
    @(posedge clk);
    #1;
    if (pif.enter_pulse === 1'b1 || pif.exit_pulse === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got enter=%b exit=%b count=%0d, expected no pulse",
                 pif.enter_pulse, pif.exit_pulse, pif.count);
      end else begin
        e = exp_q.pop_front();
        if (pif.enter_pulse !== e[6] || pif.exit_pulse !== !e[6] ||
            pif.count !== e[5:0] || pif.full !== (e[5:0] == 6'(MAXC)) ||
            pif.empty !== (e[5:0] == 6'd0)) begin
          errors++;
          $display("FAIL pulse_check: got enter=%b exit=%b count=%0d full=%b empty=%b, expected enter=%b exit=%b count=%0d full=%b empty=%b",
                   pif.enter_pulse, pif.exit_pulse, pif.count, pif.full, pif.empty,
                   e[6], !e[6], e[5:0], (e[5:0] == 6'(MAXC)), (e[5:0] == 6'd0));
        end
      end
    end
  endtask

  task automatic drive(input logic [1:0] ab, input int n);
    pif.sensor_a = ab[1];
    pif.sensor_b = ab[0];
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_entry();
    if (model_count < MAXC) model_count++;
    exp_q.push_back({1'b1, 6'(model_count)});
  endtask

  task automatic push_exit();
    if (model_count > 0) model_count--;
    exp_q.push_back({1'b0, 6'(model_count)});
  endtask

  task automatic seq4(input logic [1:0] s0, input logic [1:0] s1,
                      input logic [1:0] s2, input logic [1:0] s3);
    drive(s0, 4);
    drive(s1, 4);
    drive(s2, 4);
    drive(s3, 4);
  endtask

  task automatic do_entry();
    push_entry();
    seq4(2'b00, 2'b10, 2'b11, 2'b01);
    drive(2'b00, 4);
  endtask

  task automatic do_exit();
    push_exit();
    seq4(2'b00, 2'b01, 2'b11, 2'b10);
    drive(2'b00, 4);
  endtask

  // Confirms all expected strobes arrived and count matches the model.
  task automatic check_settled(input string name);
    checks++;
    if (exp_q.size() != 0 || pif.count !== 6'(model_count) ||
        pif.full !== (model_count == MAXC) || pif.empty !== (model_count == 0)) begin
      errors++;
      $display("FAIL %s: got count=%0d full=%b empty=%b pending=%0d, expected count=%0d pending=0",
               name, pif.count, pif.full, pif.empty, exp_q.size(), model_count);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pif.sensor_a = 1'($urandom_range(0, 1));
      pif.sensor_b = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (pif.count !== 6'd0 || pif.empty !== 1'b1 || pif.full !== 1'b0 ||
          pif.enter_pulse !== 1'b0 || pif.exit_pulse !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: got count=%0d empty=%b full=%b enter=%b exit=%b, expected 0 1 0 0 0",
                 pif.count, pif.empty, pif.full, pif.enter_pulse, pif.exit_pulse);
      end
    end
    pif.sensor_a = 1'b0;
    pif.sensor_b = 1'b0;
    tick();
    reset_n = 1'b1;
    model_count = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (pif.count !== 6'd0 || pif.empty !== 1'b1 || pif.full !== 1'b0) begin
        errors++;
        $display("FAIL reset_release: got count=%0d empty=%b full=%b, expected 0 1 0",
                 pif.count, pif.empty, pif.full);
      end
    end
  endtask

  task automatic test_entry();
    push_entry();
    seq4(2'b00, 2'b10, 2'b11, 2'b01);
    pif.sensor_a = 1'b0;
    pif.sensor_b = 1'b0;
    tick();
    tick();
    checks++;
    if (pif.enter_pulse !== 1'b0 || pif.count !== 6'd0 || pif.empty !== 1'b1) begin
      errors++;
      $display("FAIL entry_early: got enter=%b count=%0d empty=%b after 2 edges, expected 0 0 1",
               pif.enter_pulse, pif.count, pif.empty);
    end
    tick();
    checks++;
    if (pif.enter_pulse !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL entry_latency: got enter=%b pending=%0d at 3rd edge, expected enter=1 pending=0",
               pif.enter_pulse, exp_q.size());
    end
    tick();
    checks++;
    if (pif.enter_pulse !== 1'b0) begin
      errors++;
      $display("FAIL entry_width: got enter=%b one cycle after strobe, expected 0", pif.enter_pulse);
    end
    check_settled("entry_count");
  endtask

  task automatic test_exit_abort();
    do_entry();
    do_entry();
    check_settled("count_three");
    do_exit();
    check_settled("exit_count");
    seq4(2'b10, 2'b11, 2'b10, 2'b00);
    check_settled("backoff_nopulse");
    drive(2'b10, 4);
    drive(2'b01, 4);
    drive(2'b00, 4);
    check_settled("abort_nopulse");
  endtask

  task automatic test_saturation();
    while (model_count < MAXC) do_entry();
    check_settled("sat_full");
    do_entry();
    check_settled("sat_hold");
    while (model_count > 0) do_exit();
    check_settled("drain_empty");
    do_exit();
    check_settled("exit_at_zero");
  endtask

  task automatic test_mid_reset();
    do_entry();
    check_settled("pre_reset_count");
    drive(2'b10, 4);
    drive(2'b11, 4);
    reset_n = 1'b0;
    model_count = 0;
    #1;
    checks++;
    if (pif.count !== 6'd0 || pif.empty !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got count=%0d empty=%b, expected 0 1", pif.count, pif.empty);
    end
    tick();
    reset_n = 1'b1;
    drive(2'b01, 4);
    drive(2'b00, 4);
    check_settled("mid_reset_nopulse");
    do_entry();
    check_settled("post_reset_entry");
  endtask

  task automatic test_back_to_back();
    int start;
    start = model_count;
    push_entry();
    push_entry();
    drive(2'b10, 4);
    drive(2'b11, 4);
    drive(2'b01, 4);
    drive(2'b00, 1);
    drive(2'b10, 4);
    drive(2'b11, 4);
    drive(2'b01, 4);
    drive(2'b00, 4);
    check_settled("b2b_two_pulses");
    checks++;
    if (pif.count !== 6'(start + 2)) begin
      errors++;
      $display("FAIL b2b_delta: got count=%0d, expected %0d", pif.count, start + 2);
    end
  endtask

  initial begin
    pif.sensor_a = 1'b0;
    pif.sensor_b = 1'b0;
    test_reset();
    test_entry();
    test_exit_abort();
    test_saturation();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parking_occupancy_counter.md
# parking_occupancy_counter

Tracks how many cars are inside a parking lot from two photo-sensor inputs, A (outer) and B (inner), mounted across the lot gate. A direction-detecting state machine recognises complete enter and exit passages. It drives a saturating occupancy count that feeds the lot's 7-segment display stage (CLEAR/FULL/two-digit readout) directly. Single clock domain; sensor inputs are asynchronous and synchronised internally.

## Interface
- MAX_COUNT, 25, lot capacity; count saturates here
- CW, 6, count width; must satisfy 2^CW > MAX_COUNT
- clk  in  1  system clock, rising-edge
- reset_n  in  1  asynchronous, active-low reset
- sensor_a  in  1  outer beam blocked (1 = blocked), asynchronous
- sensor_b  in  1  inner beam blocked (1 = blocked), asynchronous
- count  out  CW  current occupancy, 0..MAX_COUNT
- full  out  1  count == MAX_COUNT
- empty  out  1  count == 0
- enter_pulse  out  1  one-cycle strobe, complete entry recognised
- exit_pulse  out  1  one-cycle strobe, complete exit recognised

## Operation
- Both sensors pass through a 2-flop synchroniser. Define the synced pair as ab = {a_s, b_s}. The FSM only ever sees ab.
- FSM states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ABORT.
- IDLE:
  - ab=10 → EN1
  - ab=01 → EX1
  - ab=00 → stay
  - ab=11 → ABORT
- Entry path:
  - EN1: 10 stay; 11 → EN2; 00 → IDLE (backed out); 01 → ABORT.
  - EN2: 11 stay; 01 → EN3; 10 → EN1; 00 → ABORT.
  - EN3: 01 stay; 00 → IDLE with entry recognised; 11 → EN2; 10 → ABORT.
- Exit path (mirror of entry):
  - EX1: 01 stay; 11 → EX2; 00 → IDLE; 10 → ABORT.
  - EX2: 11 stay; 10 → EX3; 01 → EX1; 00 → ABORT.
  - EX3: 10 stay; 00 → IDLE with exit recognised; 11 → EX2; 01 → ABORT.
- ABORT: stay until ab=00, then → IDLE. Nothing is counted.
- Entry recognised:
  - If count < MAX_COUNT, count increments by 1; otherwise count holds.
  - enter_pulse asserts in both cases.
- Exit recognised:
  - If count > 0, count decrements by 1; otherwise count holds.
  - exit_pulse asserts in both cases.
- enter_pulse and exit_pulse are mutually exclusive by construction; never both high.
- full and empty are decoded from the count register (combinational), so they change in the same cycle as count.
- Count arithmetic is unsigned, CW bits. count never leaves 0..MAX_COUNT.
- Reset mid-passage discards the partial sequence. After reset the FSM needs a fresh passage starting from 00; a beam held blocked through reset is handled by the IDLE rules above.

## Timing
- Reset values while reset_n=0:
  - count=0, full=0, empty=1, enter_pulse=0, exit_pulse=0
  - FSM=IDLE, synchroniser flops=0
- Sensor-to-FSM latency is 2 clk edges through the synchroniser.
- enter_pulse, exit_pulse and count are all registered. They update on the same edge that moves the FSM from EN3/EX3 to IDLE.
- The final raw transition to ab=00 is visible on count and the pulse after the 3rd rising edge.
- Pulses are exactly one cycle wide.
- Back-to-back passages need only one IDLE cycle between them; no extra dead time.
- reset_n assertion takes effect immediately (asynchronous). Release is sampled at the next rising clk edge.

## Test plan
- Reset: hold reset_n=0 with sensors toggling → count=0, empty=1, full=0, no pulses; release → outputs unchanged until the first valid passage.
- Entry: ab sequence 00,10,11,01,00, each held 4 cycles → one enter_pulse 3 edges after the final 00; count 0→1; empty falls the same cycle.
- Exit and abort:
  - From count=3, sequence 00,01,11,10,00 → one exit_pulse; count=2.
  - Sequence 10,11,10,00 (back-off) → no pulse, count unchanged.
  - Sequence 10,01,00 (ABORT) → no pulse, count unchanged.
- Saturation:
  - 25 entries → count=25 and full=1 on the 25th pulse.
  - A 26th entry → enter_pulse=1, count stays 25.
  - From count=0, one exit → exit_pulse=1, count stays 0.
- Mid-passage reset: drive 10,11, pulse reset_n low for 1 cycle, then drive 01,00 → no pulse, count=0, FSM reaches IDLE once 00 is seen.
- Back-to-back: two entries separated by a single 00 cycle → two enter_pulses; count +2.
